segment_capture: RTL and testbench

Receive-side decoder for the multiplexed four-digit seven-segment bus driven by the stopwatch display path. It samples the active-low `seg`/`an` lines, waits for each anode dwell to settle, and decodes the segment pattern back to a BCD digit. It assembles complete four-digit frames and flags blanked, invalid or malformed drive. It sits beside the display driver as an on-chip self-check and loopback monitor, and it is the reference checker for display-path benches.

---
 rtl/segment_capture.sv | 166 ++++++++++++++++
 tb/tb_segment_capture.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_capture.sv
// Receive-side decoder for the multiplexed four-digit seven-segment bus.
// Debounces each anode dwell, decodes it back to BCD and publishes complete frames.
module segment_capture #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg,
    input  logic [3:0] an,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic [3:0] blank,
    output logic [3:0] invalid,
    output logic       valid,
    output logic       frame_done,
    output logic       err
);

    localparam int unsigned   TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]    STAB_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0]    STAB_MAX  = 8'(STABLE_CYCLES);
    localparam logic [TW-1:0] TMR_LOAD  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMR_ONE   = TW'(1);

    logic [6:0]       seg_q;
    logic [3:0]       an_q;
    logic [10:0]      key_prev;
    logic [7:0]       stab_cnt;
    logic [TW-1:0]    idle_tmr;
    logic [3:0][3:0]  stg_digit;
    logic [3:0]       stg_blank;
    logic [3:0]       stg_invalid;
    logic [3:0]       seen;

    logic [10:0]      key;
    logic             diff;
    logic [7:0]       stab_next;
    logic             accept;
    logic [3:0]       an_sel;
    logic             one_hot;
    logic             multi;
    logic             capture;
    logic [3:0]       dec_digit;
    logic             dec_blank;
    logic             dec_bad;
    logic [3:0][3:0]  nxt_digit;
    logic [3:0]       nxt_blank;
    logic [3:0]       nxt_invalid;
    logic [3:0]       nxt_seen;
    logic             complete;
    logic             expire;

    // The decimal point carries no digit information and is deliberately dropped.
    logic dp_unused;
    assign dp_unused = seg[7];

    assign key       = {seg_q, an_q};
    assign diff      = (key != key_prev);
    assign stab_next = diff ? 8'd1 : ((stab_cnt == STAB_MAX) ? STAB_MAX : stab_cnt + 8'd1);
    assign accept    = !diff && (stab_cnt == STAB_LAST);

    assign an_sel  = ~an_q;
    assign one_hot = $onehot(an_sel);
    assign multi   = ($countones(an_sel) > 1);
    assign capture = accept && one_hot;

    assign err = !rst && accept && (multi || (one_hot && dec_bad));

    always_comb begin
        dec_digit = 4'd0;
        dec_blank = 1'b0;
        dec_bad   = 1'b0;
        case (seg_q)
            7'h40:   dec_digit = 4'd0;
            7'h79:   dec_digit = 4'd1;
            7'h24:   dec_digit = 4'd2;
            7'h30:   dec_digit = 4'd3;
            7'h19:   dec_digit = 4'd4;
            7'h12:   dec_digit = 4'd5;
            7'h02:   dec_digit = 4'd6;
            7'h78:   dec_digit = 4'd7;
            7'h00:   dec_digit = 4'd8;
            7'h10:   dec_digit = 4'd9;
            7'h7F:   dec_blank = 1'b1;
            default: dec_bad   = 1'b1;
        endcase
    end

    always_comb begin
        nxt_digit   = stg_digit;
        nxt_blank   = stg_blank;
        nxt_invalid = stg_invalid;
        nxt_seen    = seen;
        if (capture) begin
            for (int i = 0; i < 4; i++) begin
                if (an_sel[i]) begin
                    nxt_digit[i]   = dec_digit;
                    nxt_blank[i]   = dec_blank;
                    nxt_invalid[i] = dec_bad;
                    nxt_seen[i]    = 1'b1;
                end
            end
        end
    end

    assign complete = (nxt_seen == 4'b1111);
    // The timer parks at zero after expiry so the timeout fires only once per silence.
    assign expire   = !accept && (idle_tmr == TMR_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q       <= '0;
            an_q        <= '0;
            key_prev    <= '0;
            stab_cnt    <= '0;
            idle_tmr    <= '0;
            stg_digit   <= '0;
            stg_blank   <= '0;
            stg_invalid <= '0;
            seen        <= '0;
            digit3      <= '0;
            digit2      <= '0;
            digit1      <= '0;
            digit0      <= '0;
            blank       <= '0;
            invalid     <= '0;
            valid       <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            seg_q       <= seg[6:0];
            an_q        <= an;
            key_prev    <= key;
            stab_cnt    <= stab_next;
            stg_digit   <= nxt_digit;
            stg_blank   <= nxt_blank;
            stg_invalid <= nxt_invalid;
            frame_done  <= complete;

            if (accept) begin
                idle_tmr <= TMR_LOAD;
            end else if (idle_tmr != '0) begin
                idle_tmr <= idle_tmr - TMR_ONE;
            end

            if (complete) begin
                digit3  <= nxt_digit[3];
                digit2  <= nxt_digit[2];
                digit1  <= nxt_digit[1];
                digit0  <= nxt_digit[0];
                blank   <= nxt_blank;
                invalid <= nxt_invalid;
                valid   <= 1'b1;
                seen    <= '0;
            end else if (expire) begin
                valid   <= 1'b0;
                seen    <= '0;
            end else begin
                seen    <= nxt_seen;
            end
        end
    end

endmodule

// File: tb/tb_segment_capture.sv
// Bench for segment_capture: directed display scans checked against a window-based
// behavioural model every cycle, plus literal expectations for each scenario.
module tb_segment_capture;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 100;
    localparam logic [6:0] PATS [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                         7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] seg = 8'hFF;
    logic [3:0] an  = 4'hF;
    logic [3:0] digit3, digit2, digit1, digit0, blank, invalid;
    logic       valid, frame_done, err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fd_count = 0;
    int err_count = 0;

    segment_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .seg(seg), .an(an),
        .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
        .blank(blank), .invalid(invalid), .valid(valid),
        .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // 0..9 digit, 10 blank, 11 undecodable
    function automatic int code_of(input logic [6:0] p);
        for (int d = 0; d < 10; d++) if (p == PATS[d]) return d;
        if (p == 7'h7F) return 10;
        return 11;
    endfunction

    // Model: registered-key history since reset; a dwell is accepted when the trailing
    // run of identical keys is exactly STABLE long.
    int          hist[$];
    logic        rst_prev = 1'b0;
    logic [10:0] raw_prev = '0;
    bit          armed = 0;
    logic [3:0]  m_sd [4];
    logic [3:0]  m_sb, m_si, m_seen, m_blank, m_inv;
    logic [15:0] m_dig;
    logic        m_valid, m_fd;
    int          m_last;
    bit          m_have;

    always @(negedge clk) begin
        int n, run, code, k;
        bit acc, one, multi, exp_err;
        logic [3:0] a;
        logic [6:0] p;
        if (rst_prev) begin
            hist.delete();
            hist.push_back(0);
            armed = 1;
        end else begin
            hist.push_back(int'(raw_prev));
        end
        if (hist.size() > STABLE + 1) void'(hist.pop_front());
        n = hist.size();
        run = 0;
        for (int i = n - 1; i >= 0; i--) begin
            if (hist[i] != hist[n-1]) break;
            run++;
        end
        acc = armed && !rst && (run == STABLE);
        k = hist[n-1];
        a = 4'(k);
        p = 7'(k >> 4);
        one = acc && ($countones(~a) == 1);
        multi = acc && ($countones(~a) > 1);
        code = code_of(p);
        exp_err = multi || (one && code == 11);

        if (armed) begin
            chk("err", {31'd0, err}, {31'd0, exp_err});
            chk("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
            chk("frame_outputs", {7'd0, digit3, digit2, digit1, digit0, blank, invalid, valid},
                {7'd0, m_dig, m_blank, m_inv, m_valid});
            if (err) err_count++;
            if (frame_done) fd_count++;
        end

        if (rst) begin
            m_seen = 0; m_sb = 0; m_si = 0; m_dig = 0; m_blank = 0; m_inv = 0;
            m_valid = 0; m_fd = 0; m_have = 0; m_last = 0;
            for (int i = 0; i < 4; i++) m_sd[i] = 0;
        end else begin
            m_fd = 0;
            if (acc) begin
                m_last = cyc;
                m_have = 1;
                if (one) begin
                    for (int i = 0; i < 4; i++) begin
                        if (!a[i]) begin
                            m_sd[i]   = (code < 10) ? 4'(code) : 4'd0;
                            m_sb[i]   = (code == 10);
                            m_si[i]   = (code == 11);
                            m_seen[i] = 1'b1;
                        end
                    end
                end
            end else if (m_have && (cyc + 1 - m_last == TIMEOUT)) begin
                m_valid = 0;
                m_seen = 0;
            end
            if (m_seen == 4'hF) begin
                m_dig   = {m_sd[3], m_sd[2], m_sd[1], m_sd[0]};
                m_blank = m_sb;
                m_inv   = m_si;
                m_valid = 1;
                m_fd    = 1;
                m_seen  = 0;
            end
        end
        raw_prev = {seg[6:0], an};
        rst_prev = rst;
    end

    task automatic hold(input logic [3:0] a, input logic [6:0] p, input logic dp, input int n);
        an  = a;
        seg = {dp, p};
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int t0;
        repeat (4) @(posedge clk);
        #1;
        chk("reset_outputs", {6'd0, digit3, digit2, digit1, digit0, blank, invalid, valid, frame_done, err}, 32'd0);
        rst = 1'b0;
        hold(4'hF, 7'h7F, 1'b1, 8);

        // "12:34"; the an[2] dwell toggles dp every cycle, which must not disturb acceptance
        hold(4'b0111, 7'h79, 1'b1, 16);
        for (int i = 0; i < 16; i++) hold(4'b1011, 7'h24, 1'(i % 2), 1);
        hold(4'b1101, 7'h30, 1'b1, 16);
        hold(4'b1110, 7'h19, 1'b1, 16);
        settle();
        chk("scan1_digits", {16'd0, digit3, digit2, digit1, digit0}, 32'h1234);
        chk("scan1_valid", {31'd0, valid}, 32'd1);
        chk("scan1_flags", {24'd0, blank, invalid}, 32'd0);
        chk("scan1_frames", fd_count, 1);
        chk("scan1_errs", err_count, 0);

        // 3-cycle glitch at the tail of the an[1] dwell is too short to capture
        hold(4'b0111, 7'h79, 1'b1, 16);
        hold(4'b1011, 7'h24, 1'b1, 16);
        hold(4'b1101, 7'h30, 1'b1, 13);
        hold(4'b1101, 7'h00, 1'b1, 3);
        hold(4'b1110, 7'h19, 1'b1, 16);
        settle();
        chk("glitch_digit1", {28'd0, digit1}, 32'd3);
        chk("glitch_frames", fd_count, 2);
        chk("glitch_errs", err_count, 0);

        // blanked min-tens with 20-cycle gaps
        hold(4'b0111, 7'h7F, 1'b1, 16);
        hold(4'hF, 7'h7F, 1'b1, 20);
        hold(4'b1011, 7'h24, 1'b1, 16);
        hold(4'hF, 7'h7F, 1'b1, 20);
        hold(4'b1101, 7'h30, 1'b1, 16);
        hold(4'hF, 7'h7F, 1'b1, 20);
        hold(4'b1110, 7'h19, 1'b1, 16);
        hold(4'hF, 7'h7F, 1'b1, 20);
        chk("blank_flags", {28'd0, blank}, 32'h8);
        chk("blank_digits", {16'd0, digit3, digit2, digit1, digit0}, 32'h0234);
        chk("blank_errs", err_count, 0);
        chk("blank_frames", fd_count, 3);

        // undecodable pattern, then a two-anode dwell that must not capture
        hold(4'b1110, 7'h7E, 1'b1, 16);
        chk("bad_pattern_err", err_count, 1);
        hold(4'b1100, 7'h40, 1'b1, 16);
        chk("multi_anode_err", err_count, 2);
        hold(4'b0111, 7'h79, 1'b1, 16);
        hold(4'b1011, 7'h24, 1'b1, 16);
        chk("multi_no_capture", fd_count, 3);
        hold(4'b1101, 7'h30, 1'b1, 16);
        chk("invalid_frames", fd_count, 4);
        chk("invalid_flags", {28'd0, invalid}, 32'h1);
        chk("invalid_digits", {16'd0, digit3, digit2, digit1, digit0}, 32'h1230);

        // idle gap accepted at t0+4; valid must fall at t0+4+TIMEOUT
        an = 4'hF;
        seg = 8'hFF;
        t0 = cyc;
        while (cyc < t0 + 3 + TIMEOUT) @(negedge clk);
        #1;
        chk("timeout_before", {31'd0, valid}, 32'd1);
        settle();
        chk("timeout_after", {31'd0, valid}, 32'd0);
        chk("timeout_digits_hold", {16'd0, digit3, digit2, digit1, digit0}, 32'h1230);
        @(posedge clk);
        #1;

        // reset mid-frame discards the partial set
        hold(4'b0111, 7'h79, 1'b1, 16);
        hold(4'b1011, 7'h24, 1'b1, 16);
        rst = 1'b1;
        hold(4'hF, 7'h7F, 1'b1, 3);
        rst = 1'b0;
        hold(4'b1101, 7'h30, 1'b1, 16);
        hold(4'b1110, 7'h19, 1'b1, 16);
        hold(4'hF, 7'h7F, 1'b1, 10);
        chk("reset_mid_frames", fd_count, 4);
        chk("reset_mid_outputs", {7'd0, digit3, digit2, digit1, digit0, blank, invalid, valid}, 32'd0);

        settle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
